// File: rtl/capture_seq_if.sv
// Signal bundle between capture_seq, the command/config block, the trigger logic and the sample RAM.
// The optional force_trig input (CAP_FORCE_TRIG_EN) is a plain port on capture_seq.
interface capture_seq_if #(
    parameter int LOG2 = 9
);
    logic              run;
    logic              wrt_smpl;
    logic              triggered;
    logic [15:0]       trig_pos;
    logic              capture_done;
    logic              we;
    logic [LOG2-1:0]   waddr;
    logic              armed;
    logic              set_capture_done;
    logic [LOG2-1:0]   trace_start;
    logic              busy;

    // Command/trigger side drives the controls and observes the sequencer.
    modport master (
        output run, wrt_smpl, triggered, trig_pos, capture_done,
        input  we, waddr, armed, set_capture_done, trace_start, busy
    );

    modport slave (
        input  run, wrt_smpl, triggered, trig_pos, capture_done,
        output we, waddr, armed, set_capture_done, trace_start, busy
    );
endinterface

// File: rtl/capture_seq.sv
// capture_seq: circular-buffer capture sequencer (pre-trigger history, trigger, post-trigger fill).
// Define CAP_FORCE_TRIG_EN to add the force_trig input, which acts as a trigger while ARMED.
module capture_seq #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic         clk,
    input  logic         rst,
`ifdef CAP_FORCE_TRIG_EN
    input  logic         force_trig,
`endif
    capture_seq_if.slave bus
);

    localparam int              CNT_W     = 17;
    localparam logic [CNT_W-1:0] ENT_C    = CNT_W'(ENTRIES);
    localparam logic [LOG2-1:0]  LAST_ADR = LOG2'(ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LOG2-1:0]    r_waddr;
    logic [LOG2-1:0]    w_waddr_inc;
    logic [CNT_W-1:0]   r_pre_cnt;
    logic [CNT_W-1:0]   r_post_cnt;
    logic [CNT_W-1:0]   r_p;
    logic [CNT_W-1:0]   r_q;
    logic [CNT_W-1:0]   w_p_eff;
    logic [CNT_W-1:0]   w_q_eff;
    logic [CNT_W-1:0]   w_pre_inc;
    logic [CNT_W-1:0]   w_post_inc;
    logic               r_armed;
    logic               r_set_done;
    logic [LOG2-1:0]    r_trace_start;
    logic               w_we;
    logic               w_start;
    logic               w_trig_hit;
    logic               w_done_entry;

    // Clamp the raw post-trigger request into 1..ENTRIES.
    function automatic logic [CNT_W-1:0] eff_post(input logic [15:0] tp);
        logic [CNT_W-1:0] tp_ext;
        tp_ext = {1'b0, tp};
        if (tp == 16'd0) begin
            return CNT_W'(1);
        end else if (tp_ext > ENT_C) begin
            return ENT_C;
        end else begin
            return tp_ext;
        end
    endfunction

    assign w_p_eff     = eff_post(bus.trig_pos);
    assign w_q_eff     = ENT_C - w_p_eff;
    assign w_pre_inc   = r_pre_cnt + CNT_W'(1);
    assign w_post_inc  = r_post_cnt + CNT_W'(1);
    assign w_waddr_inc = (r_waddr == LAST_ADR) ? '0 : r_waddr + LOG2'(1);

`ifdef CAP_FORCE_TRIG_EN
    assign w_trig_hit  = bus.wrt_smpl & (bus.triggered | force_trig);
`else
    assign w_trig_hit  = bus.wrt_smpl & bus.triggered;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_start     = 1'b1;
                    w_state_nxt = (w_q_eff == '0) ? S_ARMED : S_PRETRIG;
                end
            end
            S_PRETRIG: begin
                w_we = bus.wrt_smpl;
                if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.wrt_smpl && (w_pre_inc == r_q)) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                w_we = bus.wrt_smpl;
                if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_trig_hit) begin
                    w_state_nxt = (r_p == CNT_W'(1)) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                w_we = bus.wrt_smpl;
                if (!bus.run) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.wrt_smpl && (w_post_inc == r_p)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.capture_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Abort paths go to IDLE, so DONE is only ever entered on a completed capture.
    assign w_done_entry = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_waddr       <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_p           <= CNT_W'(1);
            r_q           <= '0;
            r_armed       <= 1'b0;
            r_set_done    <= 1'b0;
            r_trace_start <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_POST);
            r_set_done <= w_done_entry;

            if (w_start) begin
                r_waddr    <= '0;
                r_pre_cnt  <= '0;
                r_post_cnt <= '0;
                r_p        <= w_p_eff;
                r_q        <= w_q_eff;
            end else begin
                if (w_we) begin
                    r_waddr <= w_waddr_inc;
                end
                if ((r_state == S_PRETRIG) && w_we) begin
                    r_pre_cnt <= w_pre_inc;
                end
                if ((r_state == S_ARMED) && w_trig_hit) begin
                    r_post_cnt <= CNT_W'(1);
                end else if ((r_state == S_POST) && w_we) begin
                    r_post_cnt <= w_post_inc;
                end
            end

            // Oldest sample of the finished capture sits just past the final write.
            if (w_done_entry) begin
                r_trace_start <= w_waddr_inc;
            end
        end
    end

    assign bus.we               = w_we;
    assign bus.waddr            = r_waddr;
    assign bus.armed            = r_armed;
    assign bus.set_capture_done = r_set_done;
    assign bus.trace_start      = r_trace_start;
    assign bus.busy             = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);

endmodule

// File: doc/capture_seq.md
CAPTURE_SEQ -- requirements
Module: capture_seq

Interface
REQ-001 Parameter ENTRIES, default 384, number of sample RAM locations (2..65535, power of two not required).
REQ-002 Parameter LOG2, default 9, address width; SHALL satisfy 2**LOG2 >= ENTRIES.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 run  input  1  capture enable from command/config; level.
REQ-006 wrt_smpl  input  1  one-cycle strobe, a new sample is valid for writing this cycle.
REQ-007 triggered  input  1  trigger detected, level from trigger logic.
REQ-008 trig_pos  input  16  requested post-trigger sample count, raw from cmd_cfg.
REQ-009 capture_done  input  1  done flag held by cmd_cfg; the host clears it.
REQ-010 we  output  1  RAM write enable.
REQ-011 waddr  output  LOG2  RAM write address.
REQ-012 armed  output  1  pre-trigger history is full and triggers are accepted.
REQ-013 set_capture_done  output  1  one-cycle pulse to cmd_cfg.
REQ-014 trace_start  output  LOG2  address of the oldest sample in a completed capture, used for readback.
REQ-015 busy  output  1  high in any state other than IDLE and DONE.

Function
REQ-016 The effective post count P SHALL be 1 when trig_pos=0, ENTRIES when trig_pos>ENTRIES, and trig_pos otherwise; P SHALL be latched on IDLE->capture; pre count Q=ENTRIES-P.
REQ-017 The states SHALL be IDLE, PRETRIG, ARMED, POST and DONE.
REQ-018 IDLE: when run=1, the block SHALL clear waddr and the counters, then go to PRETRIG, or directly to ARMED when Q=0.
REQ-019 In PRETRIG, ARMED and POST, we SHALL equal wrt_smpl combinationally; we SHALL be 0 in IDLE and DONE.
REQ-020 Each accepted write SHALL advance waddr on the next edge; ENTRIES-1 SHALL wrap to 0.
REQ-021 PRETRIG: each write SHALL increment pre_cnt; the write that makes pre_cnt=Q SHALL move the block to ARMED; triggered SHALL be ignored.
REQ-022 armed SHALL be registered: high from the first cycle in ARMED through the last cycle in POST, and low otherwise.
REQ-023 ARMED: a write with triggered=1 SHALL count as post sample 1; the block SHALL go to DONE when P=1, and to POST otherwise; triggered without wrt_smpl SHALL have no effect.
REQ-024 POST: each write SHALL increment post_cnt; the write reaching P SHALL move the block to DONE.
REQ-025 On entry to DONE, set_capture_done SHALL pulse for exactly one cycle (the cycle after the final write), and trace_start SHALL load the wrapped address following the final write.
REQ-026 DONE: the block SHALL hold while capture_done=1 and return to IDLE on the first cycle with capture_done=0.
REQ-027 Abort: run=0 in PRETRIG, ARMED or POST SHALL force IDLE next cycle, with armed=0, no set_capture_done, and trace_start unchanged.
REQ-028 Abort takes priority: if run=0 and a final write occur in the same cycle, the abort SHALL win.
REQ-029 Counter widths SHALL be 17 bits so that ENTRIES=65535 cannot overflow.

Reset
REQ-030 rst=1 at any clock edge, including mid-capture, SHALL give state=IDLE, waddr=0, trace_start=0, armed=0, set_capture_done=0 and busy=0; we SHALL be 0 while in IDLE.
REQ-031 Reset SHALL override run, wrt_smpl and triggered in the same cycle.

Configuration
REQ-032 Macro CAP_FORCE_TRIG_EN, when defined, SHALL add input force_trig (1 bit); in ARMED, force_trig=1 with wrt_smpl SHALL behave as triggered=1.
REQ-033 Without CAP_FORCE_TRIG_EN, the port and its logic SHALL be absent, and behaviour SHALL be identical to the above with force_trig=0.

Verification
REQ-034 Bench: ENTRIES=384, trig_pos=128, wrt_smpl every cycle, triggered from sample 300 -> armed rises after write 256, 128 post writes, set_capture_done pulses once, trace_start=43.
REQ-035 Bench: triggered=1 throughout PRETRIG with trig_pos=200 -> no early trigger; armed after 184 writes; the first ARMED write triggers; done after 200 post writes.
REQ-036 Bench: trig_pos=0 -> P=1, done on the triggering write; trig_pos=1000 -> armed one cycle after run, 384 post writes.
REQ-037 Bench: run dropped at post sample 50 -> IDLE next cycle, armed=0, no pulse; the next run restarts at waddr=0.
REQ-038 Bench: rst asserted mid-POST with wrt_smpl high -> all outputs 0 next cycle; capture_done held 1 keeps DONE, release returns IDLE.
REQ-039 Bench (CAP_FORCE_TRIG_EN): force_trig pulse in ARMED with triggered=0 -> capture completes as in REQ-034.
